// File: rtl/sn_ram_sched.sv
// sn_ram_sched: round-robin write arbiter for two requesters plus a flow-controlled
// scan reader for the spike RAM. Optional clear-on-read build: SN_SCAN_CLEAR_EN.
module sn_ram_sched #(
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_gnt,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_gnt,
    input  logic          scan_start,
    input  logic [AW-1:0] scan_base,
    input  logic [AW:0]   scan_len,
    output logic          scan_busy,
    output logic          scan_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   rd_addr_q;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   rd_addr_inc;
    logic [AW-1:0]   addrb_q;
    logic [AW:0]     rd_left;
    logic [AW:0]     pcnt;
    logic            rd_issue;
    logic            inflight;
    logic            room;
    logic            push;
    logic            pop;
    logic [1:0]      fcnt;
    logic            rdp;
    logic            wrp;
    logic [AW-1:0]   fa [2];
    logic [DW-1:0]   fd [2];
    logic            prio_wr1;
    logic            clr_pend;

`ifdef SN_SCAN_CLEAR_EN
    // Each issued read is followed by a zero write to the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr_pend <= 1'b0;
        else     clr_pend <= rd_issue;
    end
`else
    assign clr_pend = 1'b0;
`endif

    always_comb begin
        wr0_gnt   = 1'b0;
        wr1_gnt   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (!rst && !clr_pend) begin
            if (wr0_req && (!wr1_req || !prio_wr1)) wr0_gnt = 1'b1;
            else if (wr1_req)                        wr1_gnt = 1'b1;
        end
        if (wr0_gnt) begin
            ram_wea   = 1'b1;
            ram_addra = wr0_addr;
            ram_dina  = wr0_data;
        end else if (wr1_gnt) begin
            ram_wea   = 1'b1;
            ram_addra = wr1_addr;
            ram_dina  = wr1_data;
        end else if (clr_pend && !rst) begin
            ram_wea   = 1'b1;
            ram_addra = addrb_q;
            ram_dina  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          prio_wr1 <= 1'b0;
        else if (wr0_gnt) prio_wr1 <= 1'b1;
        else if (wr1_gnt) prio_wr1 <= 1'b0;
    end

    assign out_valid = (fcnt != 2'd0);
    assign out_addr  = fa[rdp];
    assign out_data  = fd[rdp];
    assign push      = inflight;

    // The first read goes out in the start cycle itself; the budget counts a
    // same-cycle pop as free space so the stream sustains one word per cycle.
    always_comb begin
        pop         = out_valid && out_ready;
        room        = ({1'b0, fcnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        rd_addr     = (state == S_IDLE) ? scan_base : rd_addr_q;
        rd_addr_inc = (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_ONE;
        case (state)
            S_IDLE:  rd_issue = scan_start && (scan_len != '0);
            S_ISSUE: rd_issue = (rd_left != '0) && room;
            default: rd_issue = 1'b0;
        endcase
        if (rst) rd_issue = 1'b0;
        ram_addrb = rd_issue ? rd_addr : addrb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            rd_addr_q <= '0;
            rd_left   <= '0;
            pcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan_start) begin
                        rd_addr_q <= rd_addr_inc;
                        rd_left   <= scan_len - {{AW{1'b0}}, rd_issue};
                        pcnt      <= scan_len;
                        if (scan_len != '0) begin
                            state     <= S_ISSUE;
                            scan_busy <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            scan_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (rd_issue) begin
                        rd_addr_q <= rd_addr_inc;
                        rd_left   <= rd_left - CNT_ONE;
                    end
                    if (pop) pcnt <= pcnt - CNT_ONE;
                    if (rd_left == {{AW{1'b0}}, rd_issue}) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop) begin
                        pcnt <= pcnt - CNT_ONE;
                        if (pcnt == CNT_ONE) begin
                            state     <= S_DONE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    scan_done <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            addrb_q  <= '0;
            fcnt     <= 2'd0;
            rdp      <= 1'b0;
            wrp      <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fa[i] <= '0;
                fd[i] <= '0;
            end
        end else begin
            inflight <= rd_issue;
            addrb_q  <= ram_addrb;
            if (push) begin
                fa[wrp] <= addrb_q;
                fd[wrp] <= ram_doutb;
                wrp     <= ~wrp;
            end
            if (pop) rdp <= ~rdp;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sn_ram_sched.sv
// Directed bench for sn_ram_sched with a behavioural dual-port RAM and a
// reference copy of its contents; adapts to SN_SCAN_CLEAR_EN builds.
module tb_sn_ram_sched;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr0_req, wr1_req, wr0_gnt, wr1_gnt;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          scan_start, scan_busy, scan_done;
    logic [AW-1:0] scan_base;
    logic [AW:0]   scan_len;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          ram_wea;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina, ram_doutb;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          r0, r1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          g0, g1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } arb_vec_t;
    arb_vec_t av [11];

    sn_ram_sched #(.AW(AW), .DW(DW), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        ram_doutb <= mem[ram_addrb];
    end

    function automatic logic [DW-1:0] pat(input int a);
        return 8'(a * 7 + a / 256 + 33);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wr0_gnt"},   32'(wr0_gnt),   32'd0);
        chk({tag, ".wr1_gnt"},   32'(wr1_gnt),   32'd0);
        chk({tag, ".ram_wea"},   32'(ram_wea),   32'd0);
        chk({tag, ".ram_addra"}, 32'(ram_addra), 32'd0);
        chk({tag, ".ram_dina"},  32'(ram_dina),  32'd0);
        chk({tag, ".ram_addrb"}, 32'(ram_addrb), 32'd0);
        chk({tag, ".scan_busy"}, 32'(scan_busy), 32'd0);
        chk({tag, ".scan_done"}, 32'(scan_done), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_addr"},  32'(out_addr),  32'd0);
        chk({tag, ".out_data"},  32'(out_data),  32'd0);
    endtask

    // Starts at a negedge, returns at the negedge after the DONE cycle.
    // stall=0: out_ready held high, exact cycle timing checked.
    // stall=1: out_ready pattern 1,0,0 with hold checks; inject pulses a second start.
    task automatic run_scan(input logic [AW-1:0] base, input int len, input bit stall, input bit inject);
        int            got = 0;
        int            cyc = 1;
        int            last_pop = 0;
        bit            done_seen = 1'b0;
        bit            stalled = 1'b0;
        logic [AW-1:0] hold_a = '0;
        logic [DW-1:0] hold_d = '0;
        logic [AW-1:0] ea;
        scan_base  = base;
        scan_len   = (AW + 1)'(len);
        scan_start = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        wr0_req    = 1'b0;
        while (!done_seen && cyc < 100) begin
            @(negedge clk);
            out_ready  = stall ? ((cyc % 3) == 2) : 1'b1;
            scan_start = inject && (cyc == 3);
            if (inject && cyc == 3) begin
                scan_base = 10'd500;
                scan_len  = 11'd9;
                chk("scan.busy_at_restart", 32'(scan_busy), 32'd1);
            end
            if (stalled) begin
                chk("scan.hold_valid", 32'(out_valid), 32'd1);
                chk("scan.hold_addr",  32'(out_addr),  32'(hold_a));
                chk("scan.hold_data",  32'(out_data),  32'(hold_d));
            end
            if (!stall) begin
                chk("scan.valid_t", 32'(out_valid), 32'(cyc >= 2 && cyc < 2 + len));
                chk("scan.busy_t",  32'(scan_busy), 32'(len != 0 && cyc >= 1 && cyc <= len + 1));
                chk("scan.done_t",  32'(scan_done), 32'(cyc == ((len == 0) ? 1 : len + 2)));
            end
            if (out_valid && out_ready) begin
                if (got < len) begin
                    ea = base + AW'(got);
                    chk("scan.addr", 32'(out_addr), 32'(ea));
                    chk("scan.data", 32'(out_data), 32'(ref_mem[ea]));
                end
                got++;
                last_pop = cyc;
            end
            stalled = out_valid && !out_ready;
            hold_a  = out_addr;
            hold_d  = out_data;
            if (scan_done) begin
                done_seen = 1'b1;
                if (stall && len > 0) chk("scan.done_after_last", 32'(cyc), 32'(last_pop + 1));
            end
            cyc++;
        end
        chk("scan.done_seen", 32'(done_seen), 32'd1);
        chk("scan.word_count", 32'(got), 32'(len));
        @(negedge clk);
        chk("scan.done_pulse", 32'(scan_done), 32'd0);
        chk("scan.idle_valid", 32'(out_valid), 32'd0);
        chk("scan.idle_busy",  32'(scan_busy), 32'd0);
`ifdef SN_SCAN_CLEAR_EN
        for (int i = 0; i < len; i++) ref_mem[base + AW'(i)] = '0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //      r0 r1  a0      a1      d0     d1     g0 g1  ea      ed
        av[0]  = '{1, 1, 10'd10, 10'd20, 8'h11, 8'h21, 1, 0, 10'd10, 8'h11};
        av[1]  = '{1, 1, 10'd10, 10'd20, 8'h12, 8'h22, 0, 1, 10'd20, 8'h22};
        av[2]  = '{1, 1, 10'd10, 10'd20, 8'h13, 8'h23, 1, 0, 10'd10, 8'h13};
        av[3]  = '{1, 1, 10'd10, 10'd20, 8'h14, 8'h24, 0, 1, 10'd20, 8'h24};
        av[4]  = '{1, 0, 10'd11, 10'd99, 8'h15, 8'h77, 1, 0, 10'd11, 8'h15};
        av[5]  = '{1, 0, 10'd12, 10'd99, 8'h16, 8'h77, 1, 0, 10'd12, 8'h16};
        av[6]  = '{1, 1, 10'd13, 10'd21, 8'h17, 8'h27, 0, 1, 10'd21, 8'h27};
        av[7]  = '{0, 0, 10'd1023, 10'd1023, 8'hFF, 8'hFF, 0, 0, 10'd0, 8'h00};
        av[8]  = '{0, 1, 10'd99, 10'd22, 8'h77, 8'h28, 0, 1, 10'd22, 8'h28};
        av[9]  = '{1, 1, 10'd14, 10'd23, 8'h18, 8'h29, 1, 0, 10'd14, 8'h18};
        av[10] = '{1, 1, 10'd15, 10'd24, 8'h19, 8'h2A, 0, 1, 10'd24, 8'h2A};

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        rst        = 1'b1;
        wr0_req    = 1'b1; wr0_addr = 10'd5; wr0_data = 8'hAA;
        wr1_req    = 1'b1; wr1_addr = 10'd6; wr1_data = 8'hBB;
        scan_start = 1'b0; scan_base = '0; scan_len = '0;
        out_ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            wr0_req = av[i].r0; wr0_addr = av[i].a0; wr0_data = av[i].d0;
            wr1_req = av[i].r1; wr1_addr = av[i].a1; wr1_data = av[i].d1;
            #1;
            chk("arb.wr0_gnt",   32'(wr0_gnt),   32'(av[i].g0));
            chk("arb.wr1_gnt",   32'(wr1_gnt),   32'(av[i].g1));
            chk("arb.ram_wea",   32'(ram_wea),   32'(av[i].g0 | av[i].g1));
            chk("arb.ram_addra", 32'(ram_addra), 32'(av[i].ea));
            chk("arb.ram_dina",  32'(ram_dina),  32'(av[i].ed));
            if (av[i].g0 | av[i].g1) ref_mem[av[i].ea] = av[i].ed;
            @(negedge clk);
        end
        wr0_req = 1'b0; wr1_req = 1'b0;

        run_scan(10'd1020, 8, 1'b0, 1'b0);
        run_scan(10'd8,    5, 1'b1, 1'b0);
        run_scan(10'd20,   4, 1'b0, 1'b0);
        run_scan(10'd77,   0, 1'b0, 1'b0);
        run_scan(10'd200,  3, 1'b1, 1'b1);

        // write and scan read of the same word in one cycle
        wr0_req = 1'b1; wr0_addr = 10'd40; wr0_data = 8'h99;
        #1;
        chk("same.wr0_gnt", 32'(wr0_gnt), 32'd1);
        run_scan(10'd40, 1, 1'b0, 1'b0);
`ifndef SN_SCAN_CLEAR_EN
        ref_mem[40] = 8'h99;
`endif
        run_scan(10'd40, 1, 1'b0, 1'b0);

        // reset in the middle of a stalled scan
        out_ready = 1'b0; scan_base = 10'd300; scan_len = 11'd6; scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid.busy",  32'(scan_busy), 32'd1);
        chk("mid.valid", 32'(out_valid), 32'd1);
        wr0_req = 1'b1; wr0_addr = 10'd600; wr0_data = 8'h61;
        wr1_req = 1'b1; wr1_addr = 10'd601; wr1_data = 8'h62;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        chk_zero("rst_next");
        rst = 1'b0;
        #1;
        chk("rst.rr_wr0", 32'(wr0_gnt), 32'd1);
        chk("rst.rr_wr1", 32'(wr1_gnt), 32'd0);
        ref_mem[600] = 8'h61;
        @(negedge clk);
        wr0_req = 1'b0; wr1_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst.done",  32'(scan_done), 32'd0);
            chk("post_rst.valid", 32'(out_valid), 32'd0);
            chk("post_rst.busy",  32'(scan_busy), 32'd0);
            @(negedge clk);
        end
        run_scan(10'd1020, 8, 1'b0, 1'b0);
        run_scan(10'd598,  4, 1'b1, 1'b0);

`ifdef SN_SCAN_CLEAR_EN
        wr1_req = 1'b1; wr1_addr = 10'd500; wr1_data = 8'hEE;
        scan_base = 10'd0; scan_len = 11'd4; scan_start = 1'b1; out_ready = 1'b1;
        #1;
        chk("clr.wr1_gnt_start", 32'(wr1_gnt), 32'd1);
        @(posedge clk);
        #1 scan_start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("clr.wr1_gnt", 32'(wr1_gnt), 32'(c >= 5));
            if (c <= 4) begin
                chk("clr.ram_wea",   32'(ram_wea),   32'd1);
                chk("clr.ram_addra", 32'(ram_addra), 32'(c - 1));
                chk("clr.ram_dina",  32'(ram_dina),  32'd0);
            end
            chk("clr.scan_done", 32'(scan_done), 32'(c == 6));
        end
        wr1_req = 1'b0;
        ref_mem[500] = 8'hEE;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        run_scan(10'd0, 4, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
